// File: rtl/btn_event.sv
// -----------------------------------------------------------------------------
// btn_event
//
// Purpose:
//   Converts the five raw push-buttons into clean, single-cycle events.
//   Each button goes through a 2-flop synchroniser and a debounce filter.
//   up/down produce a pulse on press. If held, they repeat: first after
//   HOLD_CYCLES, then every REPEAT_CYCLES.
//   left/right produce one pulse per press.
//   middle produces middle_p on a short press (on release), or middle_long
//   once after it has been held for HOLD_CYCLES.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   up, down,    in   raw asynchronous button levels, 1 = pressed
//   left, right,
//   middle
//   btn_level    out  [4:0] debounced levels {middle, right, left, down, up}
//   up_p, down_p out  press pulse plus auto-repeat pulses
//   left_p,      out  press pulse only
//   right_p
//   middle_p     out  short-press pulse, issued on release
//   middle_long  out  long-press pulse, issued while still held
//
// Optional build macro:
//   BTN_REPEAT_ACCEL_EN - up/down halve their repeat interval after 8 repeat
//   pulses within one hold (minimum interval 1).
// -----------------------------------------------------------------------------
module btn_event #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000,
  parameter int CNT_W           = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       middle,
  output logic [4:0] btn_level,
  output logic       up_p,
  output logic       down_p,
  output logic       left_p,
  output logic       right_p,
  output logic       middle_p,
  output logic       middle_long
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_RPT   = 2'd2,
    ST_LONG  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

`ifdef BTN_REPEAT_ACCEL_EN
  localparam int               REP_FAST      = (REPEAT_CYCLES / 2 < 1) ? 1 : REPEAT_CYCLES / 2;
  localparam logic [CNT_W-1:0] REP_FAST_LAST = CNT_W'(REP_FAST - 1);
`endif

  // Saturating increment: the counters stop at all-ones and never wrap.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    if (cnt == CNT_MAX) begin
      sat_inc = cnt;
    end else begin
      sat_inc = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Synchroniser and debounce (bit order {middle, right, left, down, up})
  // ---------------------------------------------------------------------------
  logic [4:0]       raw_s;
  logic [4:0]       s1_r;
  logic [4:0]       s2_r;
  logic [4:0]       stable_r;
  logic [4:0]       stable_d_r;
  logic [4:0]       rise_s;
  logic [CNT_W-1:0] db_cnt_r [5];

  assign raw_s     = {middle, right, left, down, up};
  assign rise_s    = stable_r & ~stable_d_r;
  assign btn_level = stable_r;

  // Two-flop synchroniser, debounce counters and the edge-detect delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_r       <= 5'b0;
      s2_r       <= 5'b0;
      stable_r   <= 5'b0;
      stable_d_r <= 5'b0;
      for (int i = 0; i < 5; i++) begin
        db_cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      s1_r       <= raw_s;
      s2_r       <= s1_r;
      stable_d_r <= stable_r;
      for (int i = 0; i < 5; i++) begin
        // A single agreeing sample restarts the count.
        if (s2_r[i] != stable_r[i]) begin
          if (db_cnt_r[i] == DB_LAST) begin
            stable_r[i] <= s2_r[i];
            db_cnt_r[i] <= CNT_ZERO;
          end else begin
            db_cnt_r[i] <= sat_inc(db_cnt_r[i]);
          end
        end else begin
          db_cnt_r[i] <= CNT_ZERO;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // up/down repeat FSMs (index 0 = up, 1 = down) and middle press FSM
  // ---------------------------------------------------------------------------
  state_t           ud_state_r [2];
  state_t           ud_state_n [2];
  logic [CNT_W-1:0] ud_hold_r  [2];
  logic [CNT_W-1:0] ud_hold_n  [2];
  logic [CNT_W-1:0] ud_rep_r   [2];
  logic [CNT_W-1:0] ud_rep_n   [2];
  logic [CNT_W-1:0] ud_rep_last_s [2];
  logic [1:0]       ud_pulse_n;
  logic [1:0]       ud_pulse_r;
  logic [1:0]       lr_pulse_n;
  logic [1:0]       lr_pulse_r;

  state_t           m_state_r;
  state_t           m_state_n;
  logic [CNT_W-1:0] m_hold_r;
  logic [CNT_W-1:0] m_hold_n;
  logic             m_short_n;
  logic             m_short_r;
  logic             m_long_n;
  logic             m_long_r;

`ifdef BTN_REPEAT_ACCEL_EN
  logic [3:0] ud_acc_r [2];
  logic [3:0] ud_acc_n [2];

  // Repeat interval shortens once 8 repeat pulses were issued in this hold.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      if (ud_acc_r[i] >= 4'd8) begin
        ud_rep_last_s[i] = REP_FAST_LAST;
      end else begin
        ud_rep_last_s[i] = REP_LAST;
      end
    end
  end
`else
  // Fixed repeat interval.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      ud_rep_last_s[i] = REP_LAST;
    end
  end
`endif

  // State register: FSM states, counters and all registered pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        ud_state_r[i] <= ST_IDLE;
        ud_hold_r[i]  <= CNT_ZERO;
        ud_rep_r[i]   <= CNT_ZERO;
`ifdef BTN_REPEAT_ACCEL_EN
        ud_acc_r[i]   <= 4'd0;
`endif
      end
      ud_pulse_r <= 2'b0;
      lr_pulse_r <= 2'b0;
      m_state_r  <= ST_IDLE;
      m_hold_r   <= CNT_ZERO;
      m_short_r  <= 1'b0;
      m_long_r   <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        ud_state_r[i] <= ud_state_n[i];
        ud_hold_r[i]  <= ud_hold_n[i];
        ud_rep_r[i]   <= ud_rep_n[i];
`ifdef BTN_REPEAT_ACCEL_EN
        ud_acc_r[i]   <= ud_acc_n[i];
`endif
      end
      ud_pulse_r <= ud_pulse_n;
      lr_pulse_r <= lr_pulse_n;
      m_state_r  <= m_state_n;
      m_hold_r   <= m_hold_n;
      m_short_r  <= m_short_n;
      m_long_r   <= m_long_n;
    end
  end

  // Next-state logic. A release (stable low) always wins over a due pulse.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      ud_state_n[i] = ud_state_r[i];
      ud_hold_n[i]  = ud_hold_r[i];
      ud_rep_n[i]   = ud_rep_r[i];
`ifdef BTN_REPEAT_ACCEL_EN
      ud_acc_n[i]   = ud_acc_r[i];
`endif
      case (ud_state_r[i])
        ST_IDLE: begin
          ud_hold_n[i] = CNT_ZERO;
          ud_rep_n[i]  = CNT_ZERO;
`ifdef BTN_REPEAT_ACCEL_EN
          ud_acc_n[i]  = 4'd0;
`endif
          if (rise_s[i]) begin
            ud_state_n[i] = ST_PRESS;
          end else begin
            ud_state_n[i] = ST_IDLE;
          end
        end
        ST_PRESS: begin
          if (!stable_r[i]) begin
            ud_state_n[i] = ST_IDLE;
          end else if (ud_hold_r[i] == HOLD_LAST) begin
            ud_state_n[i] = ST_RPT;
            ud_rep_n[i]   = CNT_ZERO;
          end else begin
            ud_hold_n[i] = sat_inc(ud_hold_r[i]);
          end
        end
        ST_RPT: begin
          if (!stable_r[i]) begin
            ud_state_n[i] = ST_IDLE;
          end else if (ud_rep_r[i] == ud_rep_last_s[i]) begin
            ud_rep_n[i] = CNT_ZERO;
`ifdef BTN_REPEAT_ACCEL_EN
            if (ud_acc_r[i] != 4'd15) begin
              ud_acc_n[i] = ud_acc_r[i] + 4'd1;
            end else begin
              ud_acc_n[i] = ud_acc_r[i];
            end
`endif
          end else begin
            ud_rep_n[i] = sat_inc(ud_rep_r[i]);
          end
        end
        default: begin
          ud_state_n[i] = ST_IDLE;
        end
      endcase
    end

    m_state_n = m_state_r;
    m_hold_n  = m_hold_r;
    case (m_state_r)
      ST_IDLE: begin
        m_hold_n = CNT_ZERO;
        if (rise_s[4]) begin
          m_state_n = ST_PRESS;
        end else begin
          m_state_n = ST_IDLE;
        end
      end
      ST_PRESS: begin
        if (!stable_r[4]) begin
          m_state_n = ST_IDLE;
        end else if (m_hold_r == HOLD_LAST) begin
          m_state_n = ST_LONG;
        end else begin
          m_hold_n = sat_inc(m_hold_r);
        end
      end
      ST_LONG: begin
        if (!stable_r[4]) begin
          m_state_n = ST_IDLE;
        end else begin
          m_state_n = ST_LONG;
        end
      end
      default: begin
        m_state_n = ST_IDLE;
      end
    endcase
  end

  // Output logic: which pulses are due on the next clock edge.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      ud_pulse_n[i] = 1'b0;
      case (ud_state_r[i])
        ST_IDLE:  ud_pulse_n[i] = rise_s[i];
        ST_PRESS: ud_pulse_n[i] = stable_r[i] && (ud_hold_r[i] == HOLD_LAST);
        ST_RPT:   ud_pulse_n[i] = stable_r[i] && (ud_rep_r[i] == ud_rep_last_s[i]);
        default:  ud_pulse_n[i] = 1'b0;
      endcase
    end

    lr_pulse_n = rise_s[3:2];

    m_short_n = 1'b0;
    m_long_n  = 1'b0;
    case (m_state_r)
      ST_PRESS: begin
        m_short_n = !stable_r[4];
        m_long_n  = stable_r[4] && (m_hold_r == HOLD_LAST);
      end
      default: begin
        m_short_n = 1'b0;
        m_long_n  = 1'b0;
      end
    endcase
  end

  assign up_p        = ud_pulse_r[0];
  assign down_p      = ud_pulse_r[1];
  assign left_p      = lr_pulse_r[0];
  assign right_p     = lr_pulse_r[1];
  assign middle_p    = m_short_r;
  assign middle_long = m_long_r;

endmodule

// File: tb/tb_btn_event.sv
// -----------------------------------------------------------------------------
// tb_btn_event
//
// Directed bench for btn_event with DEBOUNCE_CYCLES=4, HOLD_CYCLES=20 and
// REPEAT_CYCLES=5. Inputs are changed 1 time unit after a rising edge. Pulses
// are logged by the clock index at which they are seen. Expected indices are
// counted from the edge after which the raw input changed. A clean press
// first shows a pulse at +7.
// -----------------------------------------------------------------------------
module tb_btn_event;

  localparam int D = 4;
  localparam int H = 20;
  localparam int R = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       up, down, left, right, middle;
  logic [4:0] btn_level;
  logic       up_p, down_p, left_p, right_p, middle_p, middle_long;

  always #5 clk = ~clk;

  btn_event #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES(H),
    .REPEAT_CYCLES(R),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .up(up),
    .down(down),
    .left(left),
    .right(right),
    .middle(middle),
    .btn_level(btn_level),
    .up_p(up_p),
    .down_p(down_p),
    .left_p(left_p),
    .right_p(right_p),
    .middle_p(middle_p),
    .middle_long(middle_long)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         t0;
  int         up_q[$], down_q[$], left_q[$], right_q[$], mp_q[$], ml_q[$];
  logic [4:0] lvl_or;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n edges, sampling 1 unit after each edge and logging pulses.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (up_p)        up_q.push_back(cyc);
      if (down_p)      down_q.push_back(cyc);
      if (left_p)      left_q.push_back(cyc);
      if (right_p)     right_q.push_back(cyc);
      if (middle_p)    mp_q.push_back(cyc);
      if (middle_long) ml_q.push_back(cyc);
      lvl_or = lvl_or | btn_level;
    end
  endtask

  task automatic clear_logs();
    up_q.delete(); down_q.delete(); left_q.delete();
    right_q.delete(); mp_q.delete(); ml_q.delete();
    lvl_or = 5'b0;
  endtask

  function automatic int qat(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1000;
  endfunction

  initial begin
    rst = 1'b1; up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0; middle = 1'b0;
    tick(3);
    check("reset_level", int'(btn_level), 0);
    check("reset_pulses", int'({up_p, down_p, left_p, right_p, middle_p, middle_long}), 0);
    rst = 1'b0;
    tick(5);

    // 1: clean up press, held 10 cycles
    clear_logs(); t0 = cyc; up = 1'b1;
    tick(5);
    check("t1_level_before", int'(btn_level[0]), 0);
    tick(1);
    check("t1_level_rise", int'(btn_level), 1);
    check("t1_no_pulse_yet", int'(up_p), 0);
    tick(1);
    check("t1_up_p", int'(up_p), 1);
    tick(3);
    up = 1'b0;
    tick(25);
    check("t1_up_count", up_q.size(), 1);
    check("t1_up_at", qat(up_q, 0) - t0, 7);
    check("t1_level_end", int'(btn_level), 0);

    // 2: left glitches shorter than debounce
    clear_logs(); t0 = cyc;
    left = 1'b1; tick(2); left = 1'b0; tick(2);
    left = 1'b1; tick(2); left = 1'b0;
    tick(15);
    check("t2_left_level", int'(lvl_or[2]), 0);
    check("t2_left_count", left_q.size(), 0);

    // 3: down held 40 stable cycles
    clear_logs(); t0 = cyc; down = 1'b1;
    tick(40);
    down = 1'b0;
    tick(25);
    check("t3_down_count", down_q.size(), 5);
    check("t3_press", qat(down_q, 0) - t0, 7);
    check("t3_hold", qat(down_q, 1) - t0, 27);
    check("t3_rep1", qat(down_q, 2) - t0, 32);
    check("t3_rep2", qat(down_q, 3) - t0, 37);
    check("t3_rep3", qat(down_q, 4) - t0, 42);

`ifdef BTN_REPEAT_ACCEL_EN
    // 3b: long hold, interval drops to 2 after the 8th repeat
    clear_logs(); t0 = cyc; down = 1'b1;
    tick(100);
    down = 1'b0;
    tick(25);
    check("t3b_rep8", qat(down_q, 9) - t0, 67);
    check("t3b_rep9", qat(down_q, 10) - t0, 69);
    check("t3b_rep10", qat(down_q, 11) - t0, 71);
`endif

    // 4a: middle short press
    clear_logs(); t0 = cyc; middle = 1'b1;
    tick(10);
    middle = 1'b0;
    tick(25);
    check("t4a_mp_count", mp_q.size(), 1);
    check("t4a_mp_at", qat(mp_q, 0) - t0, 17);
    check("t4a_long_count", ml_q.size(), 0);

    // 4b: middle long press
    clear_logs(); t0 = cyc; middle = 1'b1;
    tick(30);
    middle = 1'b0;
    tick(25);
    check("t4b_long_count", ml_q.size(), 1);
    check("t4b_long_at", qat(ml_q, 0) - t0, 27);
    check("t4b_mp_count", mp_q.size(), 0);

    // 5: up and right on the same raw edge
    clear_logs(); t0 = cyc; up = 1'b1; right = 1'b1;
    tick(10);
    up = 1'b0; right = 1'b0;
    tick(25);
    check("t5_up_at", qat(up_q, 0) - t0, 7);
    check("t5_right_at", qat(right_q, 0) - t0, 7);
    check("t5_right_count", right_q.size(), 1);

    // 6: reset while up is in auto-repeat
    clear_logs(); t0 = cyc; up = 1'b1;
    tick(35);
    check("t6_pre_count", up_q.size(), 3);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      check("t6_rst_up_p", int'(up_p), 0);
      check("t6_rst_level", int'(btn_level), 0);
    end
    rst = 1'b0;
    clear_logs(); t0 = cyc;
    tick(34);
    check("t6_count", up_q.size(), 3);
    check("t6_press", qat(up_q, 0) - t0, 7);
    check("t6_hold", qat(up_q, 1) - t0, 27);
    check("t6_rep", qat(up_q, 2) - t0, 32);
    up = 1'b0;
    tick(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
